// File: rtl/ddr4_mrs_shadow_tracker.sv
// Snoops DRAM-side MRS commands on an RDIMM, undoes mirroring and B-side inversion,
// and keeps per-rank MR0-MR6 shadows plus tMRD/tMOD spacing checks.
module ddr4_mrs_shadow_tracker #(
  parameter string CA_MIRROR   = "OFF",
  parameter int    CS_NUM      = 2,
  parameter int    RDIMM_SLOTS = 1,
  parameter int    MC_ABITS    = 18,
  parameter int    TMRD        = 8,
  parameter int    TMOD        = 24
) (
  input  logic                ddr_ck,
  input  logic                ddr_reset_n,
  input  logic                ddr_act_n,
  input  logic [MC_ABITS-1:0] ddr_a,
  input  logic [CS_NUM-1:0]   ddr_cs_n,
  input  logic [1:0]          ddr_bg,
  input  logic [1:0]          ddr_ba,
  input  logic                init_done,
  input  logic                err_clr,
  input  logic [1:0]          shd_rd_rank,
  input  logic [2:0]          shd_rd_mr,
  output logic [17:0]         shd_rd_data,
  output logic [CS_NUM-1:0]   db_dly_dir,
  output logic                wl_active,
  output logic [CS_NUM-1:0]   mpr_mode,
  output logic                mrs_pulse,
  output logic [CS_NUM-1:0]   mrs_rank_mask,
  output logic [2:0]          mrs_num,
  output logic [17:0]         mrs_data,
  output logic                tmod_busy,
  output logic                tmrd_err,
  output logic                tmod_err
);

  // Address bits the RCD inverts on its B-side outputs: A3-A9, A11, A13, A17.
  localparam logic [17:0] INV_MASK = 18'h22BF8;
  localparam int MRD_W = $clog2(TMRD + 1);
  localparam int MOD_W = $clog2(TMOD + 1);

  logic [CS_NUM-1:0] sel;
  logic              is_mrs;
  logic              other_cmd;
  logic [20:0]       dec [CS_NUM];
  logic [17:0]       rank_rd [CS_NUM];
  logic [17:0]       first_data;
  logic [2:0]        first_num;
  logic [MRD_W-1:0]  mrd_cnt_reg;
  logic              mrs_seen_reg;
  logic [MOD_W-1:0]  mod_cnt_reg;
  logic              tmrd_set;
  logic              tmod_set;

  // Returns {mr_num[2:0], data[17:0]} as the DRAM itself would interpret the command.
  function automatic logic [20:0] mrs_decode(input logic [17:0] a, input logic [1:0] ba,
                                             input logic [1:0] bg, input logic mirror);
    logic [17:0] aa;
    logic [1:0]  bb;
    logic [1:0]  gg;
    aa = a;
    bb = ba;
    gg = bg;
    if (mirror) begin
      aa[3]  = a[4];  aa[4]  = a[3];
      aa[5]  = a[6];  aa[6]  = a[5];
      aa[7]  = a[8];  aa[8]  = a[7];
      aa[11] = a[13]; aa[13] = a[11];
      bb     = {ba[0], ba[1]};
      gg     = {bg[0], bg[1]};
    end
    if (gg[1]) begin
      aa    = aa ^ INV_MASK;
      bb    = ~bb;
      gg[0] = ~gg[0];
    end
    return {gg[0], bb[1], bb[0], aa};
  endfunction

  assign sel       = ~ddr_cs_n;
  assign is_mrs    = init_done && ddr_act_n && (ddr_a[16:14] == 3'b000) && (|sel);
  assign other_cmd = init_done && (|sel) && !is_mrs;
  assign tmrd_set  = is_mrs && mrs_seen_reg && (mrd_cnt_reg < MRD_W'(TMRD));
  assign tmod_set  = other_cmd && tmod_busy;
  assign tmod_busy = (mod_cnt_reg != '0);
  assign wl_active = |db_dly_dir;

  for (genvar gi = 0; gi < CS_NUM; gi++) begin : g_rank
    // Mirroring keys on the global rank index regardless of how ranks split over slots.
    localparam logic MIRROR = (CA_MIRROR == "ON") && (gi % 2 == 1) && (RDIMM_SLOTS > 0);

    logic [17:0] shd_reg [7];
    logic        dly_reg;
    logic        mpr_reg;
    logic [2:0]  num;
    logic [17:0] data;

    assign dec[gi] = mrs_decode(ddr_a[17:0], ddr_ba, ddr_bg, MIRROR);
    assign num     = dec[gi][20:18];
    assign data    = dec[gi][17:0];

    always_ff @(posedge ddr_ck or negedge ddr_reset_n) begin
      if (!ddr_reset_n) begin
        for (int n = 0; n < 7; n++) shd_reg[n] <= '0;
        dly_reg <= 1'b0;
        mpr_reg <= 1'b0;
      end else if (is_mrs && sel[gi] && (num != 3'd7)) begin
        shd_reg[num] <= data;
        if (num == 3'd1) dly_reg <= data[7];
        if (num == 3'd3) mpr_reg <= data[2];
      end
    end

    assign rank_rd[gi]    = (shd_rd_mr == 3'd7) ? '0 : shd_reg[shd_rd_mr];
    assign db_dly_dir[gi] = dly_reg;
    assign mpr_mode[gi]   = mpr_reg;
  end

  always_comb begin
    shd_rd_data = '0;
    for (int r = 0; r < CS_NUM; r++) begin
      if (shd_rd_rank == 2'(r)) shd_rd_data = rank_rd[r];
    end
  end

  // Descending scan so the lowest selected rank wins.
  always_comb begin
    first_data = '0;
    first_num  = '0;
    for (int r = CS_NUM - 1; r >= 0; r--) begin
      if (sel[r]) begin
        first_data = dec[r][17:0];
        first_num  = dec[r][20:18];
      end
    end
  end

  always_ff @(posedge ddr_ck or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      mrs_pulse     <= 1'b0;
      mrs_rank_mask <= '0;
      mrs_num       <= '0;
      mrs_data      <= '0;
      mrd_cnt_reg   <= '0;
      mrs_seen_reg  <= 1'b0;
      mod_cnt_reg   <= '0;
      tmrd_err      <= 1'b0;
      tmod_err      <= 1'b0;
    end else begin
      mrs_pulse <= is_mrs;
      if (is_mrs) begin
        mrs_rank_mask <= sel;
        mrs_num       <= first_num;
        mrs_data      <= first_data;
        mrd_cnt_reg   <= MRD_W'(1);
        mrs_seen_reg  <= 1'b1;
        mod_cnt_reg   <= MOD_W'(TMOD);
      end else begin
        if (mrd_cnt_reg < MRD_W'(TMRD)) mrd_cnt_reg <= mrd_cnt_reg + MRD_W'(1);
        if (mod_cnt_reg != '0) mod_cnt_reg <= mod_cnt_reg - MOD_W'(1);
      end
      tmrd_err <= tmrd_set || (tmrd_err && !err_clr);
      tmod_err <= tmod_set || (tmod_err && !err_clr);
    end
  end

endmodule

// File: doc/ddr4_mrs_shadow_tracker.md
Name: ddr4_mrs_shadow_tracker

Overview:
- Per-rank DDR4 RDIMM mode-register snooper for the RDIMM wrapper model.
- Decodes every MRS command on the DRAM-side CA bus, undoing address mirroring on odd ranks and RCD B-side inversion.
- Keeps a shadow copy of MR0–MR6 for each rank.
- Drives per-rank data-buffer delay direction (MR1 A7, write leveling) and MPR mode (MR3 A2), and checks tMRD/tMOD command spacing.

Parameters:
- CA_MIRROR, "OFF", "ON" enables address/bank mirroring decode on odd rank indices.
- CS_NUM, 2, number of chip selects/ranks (1..4).
- RDIMM_SLOTS, 1, number of slots. When 2, CS_NUM is split per slot and mirroring still keys on odd index.
- MC_ABITS, 18, CA address width. Must be ≥18; bits above 17 are ignored.
- TMRD, 8, minimum clocks between consecutive MRS edges.
- TMOD, 24, clocks after an MRS during which tmod_busy is high.

Ports:
- ddr_ck  in  1  DRAM clock; all state updates on posedge.
- ddr_reset_n  in  1  asynchronous active-low reset.
- ddr_act_n  in  1  ACT_n; must be 1 for MRS.
- ddr_a  in  MC_ABITS  address/command bus. A16..A14 = RAS_n/CAS_n/WE_n.
- ddr_cs_n  in  CS_NUM  chip selects, active low.
- ddr_bg  in  2  bank group.
- ddr_ba  in  2  bank address.
- init_done  in  1  decoding enabled only when 1.
- err_clr  in  1  synchronous clear of sticky error flags.
- shd_rd_rank  in  2  shadow read rank select.
- shd_rd_mr  in  3  shadow read MR select.
- shd_rd_data  out  18  shadow contents; combinational read.
- db_dly_dir  out  CS_NUM  per-rank MR1 A7 (write leveling enabled).
- wl_active  out  1  OR of db_dly_dir.
- mpr_mode  out  CS_NUM  per-rank MR3 A2.
- mrs_pulse  out  1  one-cycle strobe per decoded MRS.
- mrs_rank_mask  out  CS_NUM  ranks addressed by the last MRS.
- mrs_num  out  3  decoded MR number of the last MRS.
- mrs_data  out  18  decoded, de-mirrored, de-inverted A17..A0 of the last MRS.
- tmod_busy  out  1  high during the tMOD window.
- tmrd_err  out  1  sticky: MRS spacing below TMRD.
- tmod_err  out  1  sticky: non-MRS, non-DES command (any cs_n low) issued while tmod_busy.

Behaviour:
- Reset (async assert, sync-to-clock deassert irrelevant: state only moves on posedge):
  - All shadow entries = 0; db_dly_dir = 0; mpr_mode = 0; wl_active = 0.
  - mrs_pulse = 0; mrs_rank_mask = 0; mrs_num = 0; mrs_data = 0.
  - tmod_busy = 0; tmrd_err = 0; tmod_err = 0; counters cleared.
  - Reset mid-window aborts the window immediately.
- MRS detect at posedge:
  - Conditions: init_done=1, act_n=1, a[16:14]=000, and any cs_n bit low.
  - The selected rank set is every low cs_n bit (broadcast supported).
- Per-rank decode, per selected rank r:
  - mirror = (CA_MIRROR=="ON") and r odd.
  - Mirrored: swap A3/A4, A5/A6, A7/A8, A11/A13, BA0/BA1, BG0/BG1 first.
  - After the swap, side B if BG1=1. Side B inverts A3–A9, A11, A13, A17, BA0, BA1, BG0. A0–A2, A10, A12, A14–A16 are never inverted.
  - MR number = {BG0, BA1, BA0} after decode.
  - With mixed broadcast, each rank gets its own decode.
  - mrs_num and mrs_data report the lowest-index selected rank.
- Shadow update:
  - MR0–MR6: shadow[r][n] <= decoded A17..A0 one clock after the MRS edge.
  - db_dly_dir[r] / mpr_mode[r] update in the same cycle, from MR1 bit 7 / MR3 bit 2.
  - MR7 (RCD control word): mrs_pulse still fires; shadow, db_dly_dir and mpr_mode are unchanged; timers still start.
- Latency:
  - mrs_pulse, mrs_*, db_dly_dir and mpr_mode are registered: valid the cycle after the MRS edge.
  - shd_rd_data reflects a write on the same cycle mrs_pulse is high.
  - shd_rd_rank ≥ CS_NUM or shd_rd_mr = 7 returns 0.
- tMRD checking:
  - A counter saturates at TMRD.
  - On an MRS when counter < TMRD and a prior MRS exists since reset: set tmrd_err.
  - Every MRS reloads the counter to 1 and still updates the shadow.
- tMOD checking:
  - MRS sets tmod_busy for exactly TMOD cycles, starting the cycle after the edge.
  - A new MRS restarts the window.
  - A non-MRS command with cs_n low inside the window sets tmod_err.
  - DES (all cs_n high) is legal.
- Sticky flags: err_clr=1 clears both errors. If a set and err_clr coincide, the set wins.
- init_done=0: commands are ignored entirely (no timers, no errors).

Test Plan:
- Reset, then init_done=1, rank0 MRS BG=0 BA=01 A7=1 → next cycle mrs_pulse=1, mrs_num=1, db_dly_dir=2'b01, wl_active=1, shd_rd(0,1)=0x00080.
- CA_MIRROR="ON", rank1 MRS sent mirrored + side-B-inverted encoding of MR1 A7=1 → db_dly_dir[1]=1, mrs_num=1, shadow data equals unmirrored value.
- Broadcast cs_n=2'b00 MR3 A2=1, CA_MIRROR="ON" → mpr_mode=2'b11, both shadows = 0x00004, mrs_rank_mask=2'b11.
- Two MRS 5 clocks apart (TMRD=8) → tmrd_err=1 at second; err_clr → 0; next MRS 8 clocks later → stays 0.
- MRS, then ACT on cs0 at clock 10 (TMOD=24) → tmod_err=1; tmod_busy drops exactly 24 cycles after start.
- Assert reset mid-tMOD window with db_dly_dir=1 → all outputs 0 immediately; MRS with init_done=0 → no pulse.
